// File: rtl/sushi_pkg.sv
// Shared types and constants for the sushi spawn path: object codes, scheduler
// states and the 9-bit LFSR feedback definition.
package sushi_pkg;

    typedef enum logic [1:0] {
        WASABI = 2'b00,
        SUSHI1 = 2'b01,
        SUSHI2 = 2'b10,
        SUSHI3 = 2'b11
    } obj_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRAW,
        ST_LATCH,
        ST_ALLOC,
        ST_SPAWN
    } spawn_state_t;

    localparam int         LFSR_WIDTH = 9;
    // Feedback taps for x^9 + x^5 + 1: register bits 8 and 4.
    localparam logic [8:0] LFSR_TAPS  = 9'h110;

    function automatic logic [LFSR_WIDTH-1:0] lfsr9_advance(input logic [LFSR_WIDTH-1:0] q);
        return {q[LFSR_WIDTH-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/spawn_lfsr9.sv
// 9-bit Fibonacci LFSR that advances only on a step strobe. next_value is the
// value the register takes on a step, so the caller can capture it in the same edge.
module spawn_lfsr9
    import sushi_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = 9'h1FF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  step,
    output logic [LFSR_WIDTH-1:0] next_value
);

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_d;

    always_comb begin
        next_value = lfsr9_advance(lfsr_q);
        lfsr_d     = step ? next_value : lfsr_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/sushi_spawn_scheduler.sv
// Spawn scheduler: every SPAWN_INTERVAL frames draws a random value for the object
// picker, allocates the lowest free slot and offers the spawn on a valid/ready handshake.
// Optional consecutive-wasabi limit is compiled in with `define SPAWN_WASABI_LIMIT_EN.
module sushi_spawn_scheduler
    import sushi_pkg::*;
#(
    parameter int                    NUM_SLOTS      = 8,
    parameter int                    SPAWN_INTERVAL = 60,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED      = 9'h1FF
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         enable,
    input  logic                         frame_tick,
    output logic [8:0]                   rand_obj,
    input  logic [1:0]                   obj_code,
    input  logic [NUM_SLOTS-1:0]         slot_busy,
    output logic                         spawn_valid,
    input  logic                         spawn_ready,
    output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
    output logic [1:0]                   spawn_code,
    output logic                         stall,
    output logic [15:0]                  spawn_count
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int CNT_W  = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(SPAWN_INTERVAL - 1);

    spawn_state_t          state_q,       state_d;
    logic [CNT_W-1:0]      frame_cnt_q,   frame_cnt_d;
    logic [8:0]            rand_obj_q,    rand_obj_d;
    obj_code_t             code_q,        code_d;
    logic [SLOT_W-1:0]     spawn_slot_q,  spawn_slot_d;
    obj_code_t             spawn_code_q,  spawn_code_d;
    logic                  spawn_valid_q, spawn_valid_d;
    logic                  stall_q,       stall_d;
    logic [15:0]           spawn_count_q, spawn_count_d;
`ifdef SPAWN_WASABI_LIMIT_EN
    logic [1:0]            wasabi_cnt_q,  wasabi_cnt_d;
    logic                  redraw;
`endif

    logic                  lfsr_step;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic                  free_found;
    logic [SLOT_W-1:0]     free_idx;

    spawn_lfsr9 #(
        .SEED       (LFSR_SEED)
    ) u_lfsr (
        .Clk        (Clk),
        .Reset      (Reset),
        .step       (lfsr_step),
        .next_value (lfsr_next)
    );

    // Priority encoder: scanning downward leaves the lowest free index last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

`ifdef SPAWN_WASABI_LIMIT_EN
    assign redraw = (obj_code_t'(obj_code) == WASABI) && (wasabi_cnt_q == 2'd2);
`endif

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        rand_obj_d    = rand_obj_q;
        code_d        = code_q;
        spawn_slot_d  = spawn_slot_q;
        spawn_code_d  = spawn_code_q;
        spawn_valid_d = spawn_valid_q;
        stall_d       = 1'b0;
        spawn_count_d = spawn_count_q;
        lfsr_step     = 1'b0;
`ifdef SPAWN_WASABI_LIMIT_EN
        wasabi_cnt_d  = wasabi_cnt_q;
`endif

        // A pending handshake is never abandoned; elsewhere dropping enable parks the block.
        if (!enable && state_q != ST_SPAWN) begin
            state_d     = ST_IDLE;
            frame_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == LAST_FRAME) begin
                            frame_cnt_d = '0;
                            lfsr_step   = 1'b1;
                            rand_obj_d  = lfsr_next;
                            state_d     = ST_DRAW;
                        end else begin
                            frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DRAW: begin
                    state_d = ST_LATCH;
                end
                ST_LATCH: begin
                    code_d = obj_code_t'(obj_code);
`ifdef SPAWN_WASABI_LIMIT_EN
                    if (redraw) begin
                        lfsr_step  = 1'b1;
                        rand_obj_d = lfsr_next;
                        state_d    = ST_DRAW;
                    end else begin
                        state_d = ST_ALLOC;
                    end
`else
                    state_d = ST_ALLOC;
`endif
                end
                ST_ALLOC: begin
                    if (free_found) begin
                        spawn_slot_d  = free_idx;
                        spawn_code_d  = code_q;
                        spawn_valid_d = 1'b1;
                        state_d       = ST_SPAWN;
                    end else begin
                        stall_d = 1'b1;
                    end
                end
                ST_SPAWN: begin
                    if (spawn_ready) begin
                        spawn_valid_d = 1'b0;
                        spawn_count_d = spawn_count_q + 16'd1;
`ifdef SPAWN_WASABI_LIMIT_EN
                        wasabi_cnt_d  = (spawn_code_q == WASABI) ? wasabi_cnt_q + 2'd1 : 2'd0;
`endif
                        state_d       = enable ? ST_WAIT : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            frame_cnt_q   <= '0;
            rand_obj_q    <= '0;
            code_q        <= WASABI;
            spawn_slot_q  <= '0;
            spawn_code_q  <= WASABI;
            spawn_valid_q <= 1'b0;
            stall_q       <= 1'b0;
            spawn_count_q <= '0;
`ifdef SPAWN_WASABI_LIMIT_EN
            wasabi_cnt_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            rand_obj_q    <= rand_obj_d;
            code_q        <= code_d;
            spawn_slot_q  <= spawn_slot_d;
            spawn_code_q  <= spawn_code_d;
            spawn_valid_q <= spawn_valid_d;
            stall_q       <= stall_d;
            spawn_count_q <= spawn_count_d;
`ifdef SPAWN_WASABI_LIMIT_EN
            wasabi_cnt_q  <= wasabi_cnt_d;
`endif
        end
    end

    assign rand_obj    = rand_obj_q;
    assign spawn_valid = spawn_valid_q;
    assign spawn_slot  = spawn_slot_q;
    assign spawn_code  = spawn_code_q;
    assign stall       = stall_q;
    assign spawn_count = spawn_count_q;

endmodule

// File: doc/sushi_spawn_scheduler.md
# sushi_spawn_scheduler

Sequences sushi/wasabi spawning on the conveyor. Once every `SPAWN_INTERVAL` frames it draws a 9-bit random value and drives it into `object_picker`. It then captures the returned 2-bit object code, allocates the lowest free conveyor slot, and hands the spawn to the object-state logic over a valid/ready handshake. It sits between the frame-timing logic and the per-slot sushi registers.

## Interface
- `NUM_SLOTS`, 8: number of conveyor slots (2..16).
- `SPAWN_INTERVAL`, 60: frames between spawn attempts (≥1).
- `LFSR_SEED`, 9'h1FF: LFSR reset value; must be nonzero.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high.
- `enable` in 1: game running; low holds the scheduler idle.
- `frame_tick` in 1: one-cycle pulse per frame (vsync edge).
- `rand_obj` out 9: random draw to `object_picker`.
- `obj_code` in 2: `object_picker` output, registered, one-cycle latency.
- `slot_busy` in NUM_SLOTS: bit i high = slot i occupied.
- `spawn_valid` out 1: spawn request.
- `spawn_ready` in 1: consumer accepts.
- `spawn_slot` out $clog2(NUM_SLOTS): target slot.
- `spawn_code` out 2: object code, using the same encoding as `object_picker`.
- `stall` out 1: high while waiting for a free slot.
- `spawn_count` out 16: accepted spawns, wraps at 16'hFFFF→0.

## Operation
States:
- **IDLE:** `enable`=1 → WAIT.
- **WAIT:** `frame_cnt` increments on each `frame_tick`. A `frame_tick` with `frame_cnt`==SPAWN_INTERVAL-1 → DRAW and clears `frame_cnt`.
- **DRAW:** LFSR steps exactly once on entry. `rand_obj` = new LFSR value, held stable. Next cycle → LATCH.
- **LATCH:** `obj_code` is valid this cycle. Register it into `code_q`, then → ALLOC (redraw exception under Configuration).
- **ALLOC:** If any `slot_busy` bit is 0, register the lowest-index free slot into `spawn_slot`, load `spawn_code`=`code_q`, → SPAWN. Otherwise `stall`=1 and remain; re-evaluate every cycle.
- **SPAWN:** `spawn_valid`=1. `spawn_slot` and `spawn_code` stay stable until `spawn_ready`. On `spawn_valid && spawn_ready`: `spawn_count`+1, → WAIT.

Enable and reset rules:
- `enable` low in any state except SPAWN → IDLE next cycle and clears `frame_cnt`.
- In SPAWN the handshake completes first; then the block goes to IDLE if `enable` is low.
- `frame_tick` pulses outside WAIT are ignored; they are not queued.
- `frame_tick` while `enable` is low is ignored.

LFSR:
- 9-bit Fibonacci, polynomial x^9+x^5+1.
- Update: `q <= {q[7:0], q[8]^q[4]}`.
- Never reaches zero.

Reset values (next edge with `Reset`=1, regardless of state, including mid-handshake):
- state = IDLE.
- LFSR = `LFSR_SEED`.
- `rand_obj` = 0, `spawn_valid` = 0, `spawn_slot` = 0, `spawn_code` = 0, `stall` = 0, `spawn_count` = 0, `frame_cnt` = 0, wasabi counter = 0.

## Timing
- From the qualifying `frame_tick` edge to the first `spawn_valid` cycle: 4 cycles (DRAW, LATCH, ALLOC, SPAWN), assuming a free slot and no redraw.
- Each redraw adds 2 cycles.
- `spawn_valid` falls on the edge after acceptance.
- Back-to-back spawns are impossible; minimum spacing is SPAWN_INTERVAL frames.
- Slot frees in the same cycle ALLOC samples: the slot is used that cycle; there is no extra latency.
- `spawn_ready` high before `spawn_valid`: it has no effect.

## Configuration
- `SPAWN_WASABI_LIMIT_EN` defined:
  - A 2-bit counter tracks consecutive wasabi (code 00) spawns and resets on any non-00 spawn.
  - In LATCH, if `obj_code`==00 and the counter==2, → DRAW (redraw) instead of ALLOC.
  - Redraws repeat until a non-00 code is drawn.
  - The counter increments on acceptance of a 00 spawn.
- Undefined: no counter, no redraw; every drawn code is spawned.

## Structure
- Shared package `sushi_pkg` holds:
  - `obj_code_t` enum (WASABI=2'b00, SUSHI1=2'b01, SUSHI2=2'b10, SUSHI3=2'b11).
  - `spawn_state_t` enum.
  - `LFSR_TAPS` constant.
- Sub-module `spawn_lfsr9` (9-bit LFSR with step strobe and seed parameter).
- The scheduler instantiates `spawn_lfsr9`, not `object_picker`. The picker is wired alongside at the top level.

## Test plan
- **Basic spawn:** SPAWN_INTERVAL=2, LFSR_SEED=9'h001, all slots free, `spawn_ready`=1, picker attached → `rand_obj`=2, spawn slot 0 code 01 four cycles after the 2nd tick; `spawn_count`=1.
- **Stall:** `slot_busy`=8'hFF, then 8'hFB after 10 cycles → `stall` high 10 cycles, then spawn to slot 2.
- **Handshake hold:** `spawn_ready` held low 5 cycles → `spawn_valid`, slot and code stable all 5 cycles; count increments once.
- **Wasabi limit:** LFSR_SEED=9'h1FF, three spawns.
  - Macro off → codes 00 (510), 00 (508), 00 (504).
  - Macro on → third draw redraws through 496, 480, 449 and spawns code 11 (387).
- **Reset mid-SPAWN:** `Reset` while `spawn_valid`=1 → all outputs zero next cycle; state IDLE.
- **Enable drop in WAIT:** `enable` low for 3 frames then high → `frame_cnt` restarts from 0; next spawn a full interval later.
